// File: rtl/i2s_pkg.sv
// i2s_pkg: shared constants, stereo sample type and bit-counter sizing helper
// for the I2S master transmitter (i2s_clkgen, i2s_master_tx).
package i2s_pkg;

  // Sample width carried in each channel slot.
  localparam int DATA_W        = 16;
  // Default BCLK periods per channel slot.
  localparam int SLOT_BITS_DEF = 32;
  // Default MCLK cycles per BCLK period.
  localparam int BCLK_DIV_DEF  = 4;

  // One stereo sample as offered on the input port and held in the buffer.
  typedef struct packed {
    logic [DATA_W-1:0] left;
    logic [DATA_W-1:0] right;
  } stereo_t;

  // Width of a counter that spans both slots of a frame (0..2*slot_bits-1).
  function automatic int bitcnt_width(input int slot_bits);
    return $clog2(2 * slot_bits);
  endfunction

endpackage : i2s_pkg

// File: rtl/i2s_clkgen.sv
// i2s_clkgen: divides AUDIO_MCLK down to BCLK, keeps the frame bit counter and
// word clock, and exposes single-cycle strobes for the MCLK edge on which BCLK
// rises or falls. Every strobe is asserted in the cycle *before* the edge it
// names, so the parent can update its registers on that same edge.
module i2s_clkgen
  import i2s_pkg::*;
#(
  parameter int  BCLK_DIV  = BCLK_DIV_DEF,
  parameter int  SLOT_BITS = SLOT_BITS_DEF,
  localparam int CNT_W     = bitcnt_width(SLOT_BITS)
) (
  input  logic             mclk_i,
  input  logic             rst_ni,
  output logic             bclk_o,
  output logic             wclk_o,
  output logic [CNT_W-1:0] bitcnt_o,
  output logic [CNT_W-1:0] bitcnt_next_o,
  output logic             rise_stb_o,
  output logic             fall_stb_o,
  output logic             frame_stb_o
);

  localparam int DIV_W = $clog2(BCLK_DIV);

  // Divider phase on which BCLK goes high / goes low.
  localparam logic [DIV_W-1:0] RISE_AT  = DIV_W'(BCLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] FALL_AT  = DIV_W'(BCLK_DIV - 1);
  // Last bit of the frame and first bit of the right slot.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(2 * SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] RIGHT_AT = CNT_W'(SLOT_BITS);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] bitcnt_wrap;
  logic             bclk_q, bclk_d;
  logic             wclk_q, wclk_d;
  logic             rise_stb;
  logic             fall_stb;

  assign rise_stb = (div_q == RISE_AT);
  assign fall_stb = (div_q == FALL_AT);

  // Next-state logic for divider, bit counter, BCLK and WCLK.
  always_comb begin
    bitcnt_wrap = (bitcnt_q == LAST_BIT) ? '0 : bitcnt_q + CNT_W'(1);

    div_d    = fall_stb ? '0 : div_q + DIV_W'(1);
    bitcnt_d = bitcnt_q;
    bclk_d   = bclk_q;
    wclk_d   = wclk_q;

    if (rise_stb) begin
      bclk_d = 1'b1;
    end
    if (fall_stb) begin
      bclk_d   = 1'b0;
      bitcnt_d = bitcnt_wrap;
      wclk_d   = (bitcnt_wrap >= RIGHT_AT);
    end
  end

  // State registers; reset parks the counter on the last bit so the first
  // falling edge after release wraps to 0 and opens a frame.
  always_ff @(posedge mclk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q    <= '0;
      bitcnt_q <= LAST_BIT;
      bclk_q   <= 1'b0;
      wclk_q   <= 1'b1;
    end else begin
      div_q    <= div_d;
      bitcnt_q <= bitcnt_d;
      bclk_q   <= bclk_d;
      wclk_q   <= wclk_d;
    end
  end

  assign bclk_o        = bclk_q;
  assign wclk_o        = wclk_q;
  assign bitcnt_o      = bitcnt_q;
  assign bitcnt_next_o = bitcnt_wrap;
  assign rise_stb_o    = rise_stb;
  assign fall_stb_o    = fall_stb;
  assign frame_stb_o   = fall_stb && (bitcnt_q == LAST_BIT);

endmodule : i2s_clkgen

// File: rtl/i2s_master_tx.sv
// i2s_master_tx: I2S master transmitter with a one-entry sample buffer.
// Serialises 16-bit left/right samples MSB first with the one-BCLK I2S delay,
// sending an all-zero frame (and pulsing UNDERFLOW) when no sample is waiting.
// Optional receiver: define macro I2S_RX_EN to deserialise SDATA_IN at the same
// bit positions; without it the RX outputs are tied to zero.
module i2s_master_tx
  import i2s_pkg::*;
#(
  parameter int BCLK_DIV  = BCLK_DIV_DEF,
  parameter int SLOT_BITS = SLOT_BITS_DEF
) (
  input  logic              AUDIO_MCLK,
  input  logic              RESET_n,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [DATA_W-1:0] S_LDATA,
  input  logic [DATA_W-1:0] S_RDATA,
  output logic              AUDIO_BCLK,
  output logic              AUDIO_WCLK,
  output logic              SDATA_OUT,
  output logic              FRAME_START,
  output logic              UNDERFLOW,
  input  logic              SDATA_IN,
  output logic              RX_VALID,
  output logic [DATA_W-1:0] RX_LDATA,
  output logic [DATA_W-1:0] RX_RDATA
);

  localparam int CNT_W = bitcnt_width(SLOT_BITS);

  // Bit windows that carry sample data (one bit after each slot start).
  localparam logic [CNT_W-1:0] L_FIRST = CNT_W'(1);
  localparam logic [CNT_W-1:0] L_LAST  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] R_FIRST = CNT_W'(SLOT_BITS + 1);
  localparam logic [CNT_W-1:0] R_LAST  = CNT_W'(SLOT_BITS + DATA_W);

  logic [CNT_W-1:0] bitcnt;
  logic [CNT_W-1:0] bitcnt_next;
  logic             rise_stb;
  logic             fall_stb;
  logic             frame_stb;

  i2s_clkgen #(
    .BCLK_DIV (BCLK_DIV),
    .SLOT_BITS(SLOT_BITS)
  ) u_clkgen (
    .mclk_i       (AUDIO_MCLK),
    .rst_ni       (RESET_n),
    .bclk_o       (AUDIO_BCLK),
    .wclk_o       (AUDIO_WCLK),
    .bitcnt_o     (bitcnt),
    .bitcnt_next_o(bitcnt_next),
    .rise_stb_o   (rise_stb),
    .fall_stb_o   (fall_stb),
    .frame_stb_o  (frame_stb)
  );

  // ---------------------------------------------------------------------------
  // Holding buffer and transmit shifters
  // ---------------------------------------------------------------------------
  stereo_t           buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic [DATA_W-1:0] tx_l_q, tx_l_d;
  logic [DATA_W-1:0] tx_r_q, tx_r_d;
  logic              sdata_q, sdata_d;
  logic              frame_start_q, frame_start_d;
  logic              underflow_q, underflow_d;
  logic              accept;
  logic              tx_in_left;
  logic              tx_in_right;

  assign accept      = S_VALID && !buf_full_q;
  assign tx_in_left  = (bitcnt_next >= L_FIRST) && (bitcnt_next <= L_LAST);
  assign tx_in_right = (bitcnt_next >= R_FIRST) && (bitcnt_next <= R_LAST);

  // Buffer fill/drain and serialiser; the frame boundary only ever looks at
  // the registered buffer, so a same-cycle accept waits for the next frame.
  always_comb begin
    buf_d         = buf_q;
    buf_full_d    = buf_full_q;
    tx_l_d        = tx_l_q;
    tx_r_d        = tx_r_q;
    sdata_d       = sdata_q;
    frame_start_d = 1'b0;
    underflow_d   = 1'b0;

    if (accept) begin
      buf_d.left  = S_LDATA;
      buf_d.right = S_RDATA;
      buf_full_d  = 1'b1;
    end

    if (fall_stb) begin
      sdata_d = 1'b0;
      if (frame_stb) begin
        frame_start_d = 1'b1;
        if (buf_full_q) begin
          tx_l_d     = buf_q.left;
          tx_r_d     = buf_q.right;
          buf_full_d = 1'b0;
        end else begin
          tx_l_d      = '0;
          tx_r_d      = '0;
          underflow_d = 1'b1;
        end
      end else if (tx_in_left) begin
        sdata_d = tx_l_q[DATA_W-1];
        tx_l_d  = {tx_l_q[DATA_W-2:0], 1'b0};
      end else if (tx_in_right) begin
        sdata_d = tx_r_q[DATA_W-1];
        tx_r_d  = {tx_r_q[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Transmit-side state registers.
  always_ff @(posedge AUDIO_MCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      buf_q         <= '0;
      buf_full_q    <= 1'b0;
      tx_l_q        <= '0;
      tx_r_q        <= '0;
      sdata_q       <= 1'b0;
      frame_start_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      buf_q         <= buf_d;
      buf_full_q    <= buf_full_d;
      tx_l_q        <= tx_l_d;
      tx_r_q        <= tx_r_d;
      sdata_q       <= sdata_d;
      frame_start_q <= frame_start_d;
      underflow_q   <= underflow_d;
    end
  end

  assign S_READY     = !buf_full_q;
  assign SDATA_OUT   = sdata_q;
  assign FRAME_START = frame_start_q;
  assign UNDERFLOW   = underflow_q;

  // ---------------------------------------------------------------------------
  // Optional receiver
  // ---------------------------------------------------------------------------
`ifdef I2S_RX_EN
  logic [DATA_W-1:0] rx_l_q, rx_l_d;
  logic [DATA_W-1:0] rx_r_q, rx_r_d;
  logic [DATA_W-1:0] rx_ldata_q, rx_ldata_d;
  logic [DATA_W-1:0] rx_rdata_q, rx_rdata_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_primed_q, rx_primed_d;
  logic              rx_in_left;
  logic              rx_in_right;

  // Sampling happens mid-bit, so the current (not next) bit position applies.
  assign rx_in_left  = (bitcnt >= L_FIRST) && (bitcnt <= L_LAST);
  assign rx_in_right = (bitcnt >= R_FIRST) && (bitcnt <= R_LAST);

  // Shift in on BCLK rise; publish the completed frame at the frame boundary,
  // except at the first boundary after reset when no frame has been received.
  always_comb begin
    rx_l_d      = rx_l_q;
    rx_r_d      = rx_r_q;
    rx_ldata_d  = rx_ldata_q;
    rx_rdata_d  = rx_rdata_q;
    rx_valid_d  = 1'b0;
    rx_primed_d = rx_primed_q;

    if (rise_stb) begin
      if (rx_in_left) begin
        rx_l_d = {rx_l_q[DATA_W-2:0], SDATA_IN};
      end else if (rx_in_right) begin
        rx_r_d = {rx_r_q[DATA_W-2:0], SDATA_IN};
      end
    end

    if (frame_stb) begin
      rx_primed_d = 1'b1;
      if (rx_primed_q) begin
        rx_valid_d = 1'b1;
        rx_ldata_d = rx_l_q;
        rx_rdata_d = rx_r_q;
      end
    end
  end

  // Receive-side state registers.
  always_ff @(posedge AUDIO_MCLK or negedge RESET_n) begin
    if (!RESET_n) begin
      rx_l_q      <= '0;
      rx_r_q      <= '0;
      rx_ldata_q  <= '0;
      rx_rdata_q  <= '0;
      rx_valid_q  <= 1'b0;
      rx_primed_q <= 1'b0;
    end else begin
      rx_l_q      <= rx_l_d;
      rx_r_q      <= rx_r_d;
      rx_ldata_q  <= rx_ldata_d;
      rx_rdata_q  <= rx_rdata_d;
      rx_valid_q  <= rx_valid_d;
      rx_primed_q <= rx_primed_d;
    end
  end

  assign RX_VALID = rx_valid_q;
  assign RX_LDATA = rx_ldata_q;
  assign RX_RDATA = rx_rdata_q;
`else
  // Receiver absent: ports stay for pin compatibility, outputs read zero.
  logic unused_rx;
  assign unused_rx = ^{SDATA_IN, rise_stb, bitcnt};

  assign RX_VALID = 1'b0;
  assign RX_LDATA = '0;
  assign RX_RDATA = '0;
`endif

endmodule : i2s_master_tx

// File: tb/tb_i2s_master_tx.sv
// tb_i2s_master_tx: scoreboard bench for i2s_master_tx (default parameters).
// Stimulus pushes the expected content of each completed frame into a queue;
// an independent monitor reassembles frames from the serial pins and compares.
module tb_i2s_master_tx;

  logic        AUDIO_MCLK = 1'b0;
  logic        RESET_n    = 1'b1;
  logic        S_VALID    = 1'b0;
  logic        S_READY;
  logic [15:0] S_LDATA    = 16'h0000;
  logic [15:0] S_RDATA    = 16'h0000;
  logic        AUDIO_BCLK;
  logic        AUDIO_WCLK;
  logic        SDATA_OUT;
  logic        FRAME_START;
  logic        UNDERFLOW;
  logic        SDATA_IN;
  logic        RX_VALID;
  logic [15:0] RX_LDATA;
  logic [15:0] RX_RDATA;

  // Loopback so the receiver (when built in) sees the transmitted stream.
  assign SDATA_IN = SDATA_OUT;

  always #5 AUDIO_MCLK = ~AUDIO_MCLK;

  i2s_master_tx dut (
    .AUDIO_MCLK (AUDIO_MCLK),
    .RESET_n    (RESET_n),
    .S_VALID    (S_VALID),
    .S_READY    (S_READY),
    .S_LDATA    (S_LDATA),
    .S_RDATA    (S_RDATA),
    .AUDIO_BCLK (AUDIO_BCLK),
    .AUDIO_WCLK (AUDIO_WCLK),
    .SDATA_OUT  (SDATA_OUT),
    .FRAME_START(FRAME_START),
    .UNDERFLOW  (UNDERFLOW),
    .SDATA_IN   (SDATA_IN),
    .RX_VALID   (RX_VALID),
    .RX_LDATA   (RX_LDATA),
    .RX_RDATA   (RX_RDATA)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        uf;
  } exp_t;

  exp_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Serial image of one frame: bit n of the result is the bit sent at BITCNT n.
  function automatic logic [63:0] frame_image(input logic [15:0] l, input logic [15:0] r);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      v[1 + i]  = l[15 - i];
      v[33 + i] = r[15 - i];
    end
    return v;
  endfunction

  task automatic push_frame(input logic [15:0] l, input logic [15:0] r, input logic uf);
    exp_t e;
    e.l  = l;
    e.r  = r;
    e.uf = uf;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string name);
    chk(name,
        64'({AUDIO_BCLK, AUDIO_WCLK, SDATA_OUT, FRAME_START, UNDERFLOW,
             RX_VALID, RX_LDATA, RX_RDATA, S_READY}),
        64'({1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1}));
  endtask

  // Asserts reset off-edge, checks the outputs, releases on a falling MCLK edge.
  task automatic apply_reset(input string name);
    #2 RESET_n = 1'b0;
    #1 check_reset_outputs(name);
    S_VALID = 1'b0;
    repeat (3) @(negedge AUDIO_MCLK);
    RESET_n = 1'b1;
  endtask

  task automatic wait_frame_starts(input int n, input string name);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < n * 300 + 50) begin
      @(negedge AUDIO_MCLK);
      cyc++;
      if (FRAME_START) seen++;
    end
    if (seen < n) chk(name, 64'(seen), 64'(n));
  endtask

  // Offer one sample, hold it until accepted (bounded), then withdraw.
  task automatic send(input logic [15:0] l, input logic [15:0] r);
    int waited = 0;
    S_LDATA = l;
    S_RDATA = r;
    S_VALID = 1'b1;
    while (!S_READY && waited < 1000) begin
      @(negedge AUDIO_MCLK);
      waited++;
    end
    if (!S_READY) chk("send_timeout", 64'(S_READY), 64'(1));
    @(negedge AUDIO_MCLK);
    S_VALID = 1'b0;
  endtask

  // Monitor: rebuilds each frame from the pins and compares it to the queue.
  initial begin : monitor
    logic        in_frame;
    logic        have_rise;
    logic        prev_bclk;
    int          cyc, pos, uf_cnt, since_rise, min_per, max_per;
    logic [63:0] dbits, wbits;
    exp_t        e;
    in_frame = 1'b0; have_rise = 1'b0; prev_bclk = 1'b0;
    cyc = 0; pos = 0; uf_cnt = 0; since_rise = 0; min_per = 1000; max_per = 0;
    dbits = '0; wbits = '0;
    forever begin
      @(negedge AUDIO_MCLK);
      if (!RESET_n) begin
        in_frame  = 1'b0;
        have_rise = 1'b0;
        prev_bclk = 1'b0;
      end else begin
        cyc++;
        since_rise++;
        if (FRAME_START) begin
          if (in_frame) begin
            if (exp_q.size() == 0) begin
              total_cnt++;
              $display("FAIL frame_expected: got a completed frame, required none queued");
            end else begin
              e = exp_q.pop_front();
              chk("frame_data", dbits, frame_image(e.l, e.r));
              chk("frame_underflow", 64'(uf_cnt), 64'(e.uf));
              chk("frame_len_mclk", 64'(cyc), 64'(256));
              chk("bits_per_frame", 64'(pos), 64'(64));
              chk("wclk_pattern", wbits, 64'hFFFF_FFFF_0000_0000);
              chk("bclk_period_min", 64'(min_per), 64'(4));
              chk("bclk_period_max", 64'(max_per), 64'(4));
`ifdef I2S_RX_EN
              chk("rx_frame", 64'({RX_VALID, RX_LDATA, RX_RDATA}), 64'({1'b1, e.l, e.r}));
`else
              chk("rx_idle", 64'({RX_VALID, RX_LDATA, RX_RDATA}), 64'(0));
`endif
              $display("frame L=%04h R=%04h uf=%0d checked", e.l, e.r, e.uf);
            end
          end else begin
            chk("rx_first_boundary", 64'({RX_VALID, RX_LDATA, RX_RDATA}), 64'(0));
          end
          in_frame = 1'b1;
          cyc = 0; pos = 0; uf_cnt = 0; min_per = 1000; max_per = 0;
          dbits = '0; wbits = '0;
        end
        if (UNDERFLOW) uf_cnt++;
        if (AUDIO_BCLK && !prev_bclk) begin
          if (have_rise && in_frame) begin
            if (since_rise < min_per) min_per = since_rise;
            if (since_rise > max_per) max_per = since_rise;
          end
          have_rise  = 1'b1;
          since_rise = 0;
          if (in_frame && pos < 64) begin
            dbits[pos] = SDATA_OUT;
            wbits[pos] = AUDIO_WCLK;
          end
          pos++;
        end
        prev_bclk = AUDIO_BCLK;
      end
    end
  end

  initial begin : stimulus
    int waited;

    // Reset state.
    apply_reset("reset_state");

    // Continuous valid with a constant sample: every frame carries it.
    S_LDATA = 16'hA55A;
    S_RDATA = 16'h8001;
    S_VALID = 1'b1;
    repeat (3) push_frame(16'hA55A, 16'h8001, 1'b0);
    wait_frame_starts(4, "continuous_timeout");
    apply_reset("reset_after_continuous");

    // No offers: all-zero frames, one UNDERFLOW each, buffer stays empty.
    repeat (3) push_frame(16'h0000, 16'h0000, 1'b1);
    wait_frame_starts(4, "idle_timeout");
    chk("idle_ready", 64'(S_READY), 64'(1));
    apply_reset("reset_after_idle");

    // Accept landing exactly on the first frame boundary (4th MCLK edge).
    repeat (3) @(negedge AUDIO_MCLK);
    S_LDATA = 16'hC3A5;
    S_RDATA = 16'h0F1E;
    S_VALID = 1'b1;
    @(negedge AUDIO_MCLK);
    chk("boundary_accept_flags", 64'({FRAME_START, UNDERFLOW, S_READY}), 64'(3'b110));
    S_VALID = 1'b0;
    S_LDATA = 16'hFFFF;
    S_RDATA = 16'hFFFF;
    push_frame(16'h0000, 16'h0000, 1'b1);
    push_frame(16'hC3A5, 16'h0F1E, 1'b0);
    push_frame(16'h0000, 16'h0000, 1'b1);
    wait_frame_starts(3, "boundary_timeout");
    apply_reset("reset_after_boundary");

    // Back-to-back offers: the second waits for the frame boundary.
    send(16'h7FFF, 16'h8000);
    S_LDATA = 16'h0001;
    S_RDATA = 16'hFFFE;
    S_VALID = 1'b1;
    chk("b2b_ready_low", 64'(S_READY), 64'(0));
    waited = 0;
    while (!S_READY && waited < 50) begin
      @(negedge AUDIO_MCLK);
      waited++;
    end
    chk("b2b_wait_cycles", 64'(waited), 64'(3));
    @(negedge AUDIO_MCLK);
    S_VALID = 1'b0;
    push_frame(16'h7FFF, 16'h8000, 1'b0);
    push_frame(16'h0001, 16'hFFFE, 1'b0);
    push_frame(16'h0000, 16'h0000, 1'b1);
    wait_frame_starts(3, "b2b_timeout");
    apply_reset("reset_after_b2b");

    // Reset in the middle of bit 20 with a sample still buffered.
    send(16'h1357, 16'h2468);
    send(16'h9ABC, 16'hDEF0);
    repeat (80) @(negedge AUDIO_MCLK);
    apply_reset("reset_mid_frame");
    repeat (2) push_frame(16'h0000, 16'h0000, 1'b1);
    wait_frame_starts(3, "post_reset_timeout");
    apply_reset("reset_after_midframe");

    // Loopback frame, received at the following boundary when RX is built in.
    send(16'h1234, 16'hFEDC);
    push_frame(16'h1234, 16'hFEDC, 1'b0);
    wait_frame_starts(2, "loopback_timeout");

    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_i2s_master_tx
